systolic_matmul_core: RTL and testbench

- Output-stationary systolic matrix multiplier. Computes C = A x B, where A is array_height_p x K and B is K x array_width_p.
- The inner dimension K is set at run time: the number of operand groups streamed in before a flush.
- Operands enter on one serial valid/ready byte stream; results leave on one serial valid/yumi stream.
- Top level of the matrix-multiply accelerator tile, driven by the host bus adapter.

---
 rtl/systolic_pkg.sv | 27 ++
 rtl/systolic_matmul_core_if.sv | 23 ++
 rtl/systolic_pe.sv | 87 ++++++++
 rtl/systolic_matmul_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_systolic_matmul_core.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and sizing helpers for the systolic matmul tile
package systolic_pkg;

    // Raw state codes kept for tools and scripts that expect plain constants.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        FLUSH   = ST_FLUSH,
        DRAIN   = ST_DRAIN
    } state_e;

    // Words per operand group: one B row (W words) followed by one A column (H words).
    function automatic int group_len(input int w, input int h);
        return w + h;
    endfunction

    // Number of C elements presented during drain.
    function automatic int result_count(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/systolic_matmul_core_if.sv
// rtl/systolic_matmul_core_if.sv - operand input stream and result output stream of the matmul tile
interface systolic_matmul_core_if #(
    parameter int width_p = 8
);
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic               valid_o;
    logic               yumi_i;
    logic [width_p-1:0] data_o;

    // Host side: drives operands and consumes results.
    modport master (
        output valid_i, data_i, yumi_i,
        input  ready_o, valid_o, data_o
    );

    // Core side.
    modport slave (
        input  valid_i, data_i, yumi_i,
        output ready_o, valid_o, data_o
    );
endinterface

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one multiply-accumulate cell; SYSTOLIC_SATURATE_EN selects saturating math
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic               v_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               v_o,
    output logic [width_p-1:0] a_o,
    output logic [width_p-1:0] b_o,
    output logic [width_p-1:0] acc_o,
    output logic               sat_o
);

    logic [width_p-1:0] acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [width_p-1:0] a_q, b_q;
    logic               v_q;

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic [width_p-1:0] MAX_W = '1;
    logic [2*width_p-1:0] prod_full;
    logic                 prod_ovf;
    logic [width_p-1:0]   prod_sat;
    logic [width_p:0]     sum_full;

    // Saturating multiply-accumulate with a sticky overflow flag.
    always_comb begin
        acc_d     = acc_q;
        sat_d     = sat_q;
        prod_full = {{width_p{1'b0}}, a_i} * {{width_p{1'b0}}, b_i};
        prod_ovf  = |prod_full[2*width_p-1:width_p];
        prod_sat  = prod_ovf ? MAX_W : prod_full[width_p-1:0];
        sum_full  = {1'b0, acc_q} + {1'b0, prod_sat};
        if (v_i) begin
            acc_d = sum_full[width_p] ? MAX_W : sum_full[width_p-1:0];
            if (prod_ovf || sum_full[width_p]) begin
                sat_d = 1'b1;
            end
        end
    end
`else
    // Wrapping multiply-accumulate; product and sum truncate to width_p.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (v_i) begin
            acc_d = acc_q + a_i * b_i;
        end
    end
`endif

    // Accumulator and operand pass-through registers; clear wins over accumulate.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            acc_q <= '0;
            sat_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= 1'b0;
        end else if (en_i) begin
            if (clr_i) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else begin
                acc_q <= acc_d;
                sat_q <= sat_d;
            end
            a_q <= a_i;
            b_q <= b_i;
            v_q <= v_i;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign v_o   = v_q;
    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/systolic_matmul_core.sv
// rtl/systolic_matmul_core.sv - output-stationary systolic C = A x B tile; SYSTOLIC_SATURATE_EN adds saturation and a status word
module systolic_matmul_core
    import systolic_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic                  flush_i,
    systolic_matmul_core_if.slave bus
);

    localparam int W = array_width_p;
    localparam int H = array_height_p;
    localparam int N = group_len(W, H);
`ifdef SYSTOLIC_SATURATE_EN
    localparam int R = result_count(W, H) + 1;
`else
    localparam int R = result_count(W, H);
`endif
    localparam int CW = $clog2(N);
    localparam int OW = $clog2(R);
    localparam logic [CW-1:0] LAST_WORD  = CW'(N - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(N - 1);
    localparam logic [OW-1:0] LAST_OUT   = OW'(R - 1);

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [OW-1:0] oidx_q, oidx_d;

    logic [width_p-1:0] coll_q [N];
    logic [width_p-1:0] grp_w  [N];
    logic [width_p-1:0] obuf_q [R];

    logic [width_p-1:0] a_w   [H][W+1];
    logic               v_w   [H][W+1];
    logic [width_p-1:0] b_w   [H+1][W];
    logic [width_p-1:0] acc_w [H*W];
    logic [H*W-1:0]     sat_vec;

    logic flush_take, accept, group_done, take, copy;

    // Flush pre-empts a same-cycle word; only IDLE/COLLECT honour it.
    assign flush_take = en_i & flush_i & ((state_q == IDLE) || (state_q == COLLECT));
    assign accept     = en_i & bus.valid_i & ready_q & ~flush_take;
    assign group_done = accept & (wcnt_q == LAST_WORD);
    assign take       = en_i & bus.yumi_i & (state_q == DRAIN);
    assign copy       = en_i & (state_q == FLUSH) & (fcnt_q == FLUSH_LAST);

    // Next-state logic for the collect / flush / drain sequencer.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        fcnt_d  = fcnt_q;
        oidx_d  = oidx_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (flush_take) begin
                    state_d = FLUSH;
                    wcnt_d  = '0;
                    fcnt_d  = '0;
                end else if (accept) begin
                    if (group_done) begin
                        state_d = IDLE;
                        wcnt_d  = '0;
                    end else begin
                        state_d = COLLECT;
                        wcnt_d  = wcnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (copy) begin
                    state_d = DRAIN;
                    oidx_d  = '0;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (take) begin
                    if (oidx_q == LAST_OUT) begin
                        state_d = IDLE;
                        oidx_d  = '0;
                    end else begin
                        oidx_d = oidx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // One bubble after every accepted word; closed outside IDLE/COLLECT.
        ready_d = ((state_d == IDLE) || (state_d == COLLECT)) & ~accept;
    end

    // Sequencer registers; a low en_i freezes everything.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            wcnt_q  <= '0;
            fcnt_q  <= '0;
            oidx_q  <= '0;
        end else if (en_i) begin
            state_q <= state_d;
            ready_q <= ready_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
            oidx_q  <= oidx_d;
        end
    end

    // Collection buffer for the words of the group being assembled.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < N; i++) begin
                coll_q[i] <= '0;
            end
        end else if (accept) begin
            coll_q[wcnt_q] <= bus.data_i;
        end
    end

    // The final word bypasses the buffer so the group injects right after it lands.
    for (genvar i = 0; i < N - 1; i++) begin : g_grp
        assign grp_w[i] = coll_q[i];
    end
    assign grp_w[N-1] = bus.data_i;

    for (genvar r = 0; r < H; r++) begin : g_row_skew
        logic [width_p-1:0] sk_q  [r+1];
        logic               skv_q [r+1];

        // Row r edge register followed by r delay stages.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                for (int j = 0; j <= r; j++) begin
                    sk_q[j]  <= '0;
                    skv_q[j] <= 1'b0;
                end
            end else if (en_i) begin
                if (group_done) begin
                    sk_q[0] <= grp_w[W+r];
                end
                skv_q[0] <= group_done;
                for (int j = 1; j <= r; j++) begin
                    sk_q[j]  <= sk_q[j-1];
                    skv_q[j] <= skv_q[j-1];
                end
            end
        end

        assign a_w[r][0] = sk_q[r];
        assign v_w[r][0] = skv_q[r];
    end

    for (genvar c = 0; c < W; c++) begin : g_col_skew
        logic [width_p-1:0] sk_q [c+1];

        // Column c edge register followed by c delay stages.
        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                for (int j = 0; j <= c; j++) begin
                    sk_q[j] <= '0;
                end
            end else if (en_i) begin
                if (group_done) begin
                    sk_q[0] <= grp_w[c];
                end
                for (int j = 1; j <= c; j++) begin
                    sk_q[j] <= sk_q[j-1];
                end
            end
        end

        assign b_w[0][c] = sk_q[c];
    end

    // a and b meet at PE(r,c) after r+c cycles, so the a-path valid qualifies both.
    for (genvar r = 0; r < H; r++) begin : g_pe_row
        for (genvar c = 0; c < W; c++) begin : g_pe_col
            systolic_pe #(
                .width_p (width_p)
            ) u_pe (
                .clk_i   (clk_i),
                .reset_i (reset_i),
                .en_i    (en_i),
                .clr_i   (copy),
                .v_i     (v_w[r][c]),
                .a_i     (a_w[r][c]),
                .b_i     (b_w[r][c]),
                .v_o     (v_w[r][c+1]),
                .a_o     (a_w[r][c+1]),
                .b_o     (b_w[r+1][c]),
                .acc_o   (acc_w[r*W+c]),
                .sat_o   (sat_vec[r*W+c])
            );
        end
    end

    // Operands leaving the far edges of the array have no consumer.
    logic [H-1:0] unused_row;
    logic [W-1:0] unused_col;
    for (genvar r = 0; r < H; r++) begin : g_row_sink
        assign unused_row[r] = ^{a_w[r][W], v_w[r][W]};
    end
    for (genvar c = 0; c < W; c++) begin : g_col_sink
        assign unused_col[c] = ^b_w[H][c];
    end

`ifndef SYSTOLIC_SATURATE_EN
    logic unused_sat;
    assign unused_sat = ^sat_vec;
`endif

    // Snapshot the accumulators (row-major) at the end of the flush wait.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < R; i++) begin
                obuf_q[i] <= '0;
            end
        end else if (copy) begin
            for (int i = 0; i < H * W; i++) begin
                obuf_q[i] <= acc_w[i];
            end
`ifdef SYSTOLIC_SATURATE_EN
            obuf_q[R-1] <= {{(width_p-1){1'b0}}, |sat_vec};
`endif
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.valid_o = (state_q == DRAIN);
    assign bus.data_o  = (state_q == DRAIN) ? obuf_q[oidx_q] : '0;

endmodule

// File: tb/tb_systolic_matmul_core.sv
// tb/tb_systolic_matmul_core.sv - directed scoreboard bench for systolic_matmul_core (honours SYSTOLIC_SATURATE_EN)
module tb_systolic_matmul_core;

    localparam int WP = 8;
    localparam int AW = 2;
    localparam int AH = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic en;
    logic flush;

    systolic_matmul_core_if #(.width_p(WP)) bus ();

    systolic_matmul_core #(
        .width_p        (WP),
        .array_width_p  (AW),
        .array_height_p (AH)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .en_i    (en),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int model_c [AH][AW];
    int model_sat = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === 32'(expv))
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic send_word(input int w);
        int t = 0;
        bus.data_i  = WP'(w);
        bus.valid_i = 1'b1;
        while (bus.ready_o !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'(t), 0);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // Reference accumulation of one rank-1 update: C[r][c] += A[r][k]*B[k][c].
    task automatic model_add(input int b0, input int b1, input int a0, input int a1);
        int bv[AW];
        int av[AH];
        int p;
        int s;
        bv[0] = b0; bv[1] = b1;
        av[0] = a0; av[1] = a1;
        for (int r = 0; r < AH; r++) begin
            for (int c = 0; c < AW; c++) begin
                p = av[r] * bv[c];
`ifdef SYSTOLIC_SATURATE_EN
                if (p > 255) begin p = 255; model_sat = 1; end
                s = model_c[r][c] + p;
                if (s > 255) begin s = 255; model_sat = 1; end
`else
                s = (model_c[r][c] + p) % 256;
`endif
                model_c[r][c] = s;
            end
        end
    endtask

    task automatic send_group(input int b0, input int b1, input int a0, input int a1);
        send_word(b0);
        send_word(b1);
        send_word(a0);
        send_word(a1);
        model_add(b0, b1, a0, a1);
    endtask

    task automatic model_clear();
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++)
                model_c[r][c] = 0;
        model_sat = 0;
    endtask

    task automatic flush_push();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++)
                exp_q.push_back(model_c[r][c]);
`ifdef SYSTOLIC_SATURATE_EN
        exp_q.push_back(model_sat);
`endif
        model_clear();
    endtask

    task automatic drain_all();
        int t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.valid_o === 1'b1) begin
                chk("drain_data", 32'(bus.data_o), exp_q.pop_front());
                bus.yumi_i = 1'b1;
            end else begin
                bus.yumi_i = 1'b0;
                chk("idle_data_zero", 32'(bus.data_o), 0);
            end
        end
        if (t >= 200) chk("drain_timeout", 32'(exp_q.size()), 0);
        @(negedge clk);
        bus.yumi_i = 1'b0;
        chk("post_drain_valid", 32'(bus.valid_o), 0);
        chk("post_drain_data", 32'(bus.data_o), 0);
        chk("post_drain_ready", 32'(bus.ready_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        en          = 1'b1;
        flush       = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.yumi_i  = 1'b0;
        model_clear();

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(bus.ready_o), 0);
        chk("reset_valid", 32'(bus.valid_o), 0);
        chk("reset_data", 32'(bus.data_o), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.ready_o), 1);

        // A = B = [[1,2],[3,4]] -> C = [[7,10],[15,22]].
        send_group(3, 4, 2, 4);
        send_group(1, 2, 1, 3);
        chk("model_c00", 32'(model_c[0][0]), 7);
        chk("model_c11", 32'(model_c[1][1]), 22);
        flush_push();
        drain_all();

        // No flush: nothing comes out.
        send_group(3, 4, 2, 4);
        send_group(1, 2, 1, 3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("noflush_out", {bus.valid_o, 23'd0, bus.data_o}, 0);
        end
        flush_push();
        drain_all();

        // Accumulators cleared by the previous flush.
        send_group(1, 1, 1, 1);
        flush_push();
        drain_all();

        // Partial group discarded.
        send_word(5);
        send_word(6);
        send_word(7);
        flush_push();
        drain_all();

        // en_i low: a pending word must not be taken.
        bus.data_i  = 8'd2;
        bus.valid_i = 1'b1;
        en          = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("en_low_ready_held", 32'(bus.ready_o), 1);
        en = 1'b1;
        send_group(2, 3, 4, 5);
        flush_push();
        drain_all();

        // Consumer stalls in DRAIN; flush pulses ignored.
        send_group(3, 4, 2, 4);
        send_group(1, 2, 1, 3);
        flush_push();
        begin
            int t = 0;
            while (bus.valid_o !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("stall_valid_seen", 32'(bus.valid_o), 1);
        end
        for (int i = 0; i < 10; i++) begin
            flush = (i == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("stall_data", 32'(bus.data_o), exp_q[0]);
            chk("stall_ready", 32'(bus.ready_o), 0);
        end
        flush = 1'b0;
        chk("stall_first_is_7", 32'(exp_q[0]), 7);
        drain_all();

        // Overflow: 200*200 wraps to 64 or saturates to 255.
        send_group(200, 200, 200, 200);
`ifdef SYSTOLIC_SATURATE_EN
        chk("model_ovf", 32'(model_c[0][1]), 255);
`else
        chk("model_ovf", 32'(model_c[0][1]), 64);
`endif
        flush_push();
        drain_all();

        // Reset mid-group aborts and restarts cleanly.
        send_word(9);
        send_word(9);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_ready", 32'(bus.ready_o), 0);
        chk("midreset_valid", 32'(bus.valid_o), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready_back", 32'(bus.ready_o), 1);
        send_group(1, 1, 1, 1);
        flush_push();
        drain_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
